// File: rtl/tex_dcr_regfile.sv
// Texture DCR register file: per-stage shadow banks written by DCR writes,
// copied to active banks on commit, and read through a 1-cycle lookup port.

package tex_dcr_pkg;
  localparam int LOD_MAX     = 11;
  localparam int LOD_BITS    = 4;
  localparam int DIM_BITS    = 11;
  localparam int MIPOFF_BITS = 2*DIM_BITS + 1;

  typedef struct packed {
    logic [LOD_MAX:0][MIPOFF_BITS-1:0] mipoff;
    logic [1:0][1:0]                   wraps;
    logic                              filter;
    logic [2:0]                        format;
    logic [1:0][LOD_BITS-1:0]          logdims;
    logic [31:0]                       baddr;
  } tex_dcrs_t;
endpackage

// One texture stage: shadow copy takes DCR writes, active copy is what lookups see.
module tex_dcr_bank import tex_dcr_pkg::*; (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [11:0] wr_off,
  input  logic [31:0] wr_data,
  input  logic        commit,
  output tex_dcrs_t   active
);
  localparam int MIB = $clog2(LOD_MAX + 1);

  tex_dcrs_t        shadow;
  logic [MIB-1:0]   mip_idx;

  assign mip_idx = MIB'(wr_off - 12'd6);

  // Field decode into the shadow copy; wr_en is only raised for legal field offsets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (wr_en) begin
      case (wr_off)
        12'd1: shadow.baddr <= wr_data;
        12'd2: begin
          shadow.logdims[0] <= wr_data[LOD_BITS-1:0];
          shadow.logdims[1] <= wr_data[16 +: LOD_BITS];
        end
        12'd3: shadow.format <= wr_data[2:0];
        12'd4: shadow.filter <= wr_data[0];
        12'd5: begin
          shadow.wraps[0] <= wr_data[1:0];
          shadow.wraps[1] <= wr_data[17:16];
        end
        default: if (wr_off >= 12'd6) shadow.mipoff[mip_idx] <= wr_data[MIPOFF_BITS-1:0];
      endcase
    end
  end

  // Commit samples the pre-edge shadow, so a same-cycle write is not copied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    active <= '0;
    else if (commit) active <= shadow;
  end
endmodule

module tex_dcr_regfile import tex_dcr_pkg::*; #(
  parameter int          NUM_STAGES = 2,
  parameter logic [11:0] DCR_BASE   = 12'h010,
  localparam int         SB         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         dcr_wr_valid,
  input  logic [11:0]                  dcr_wr_addr,
  input  logic [31:0]                  dcr_wr_data,
  input  logic                         commit,
  input  logic                         req_valid,
  input  logic [SB-1:0]                req_stage,
  output logic                         req_ready,
  output logic                         rsp_valid,
  output logic [$bits(tex_dcrs_t)-1:0] rsp_dcrs,
  input  logic                         rsp_ready
);
  localparam int NSLOT = 2**SB;

  logic [11:0]   off;
  logic          legal;
  logic          fld_wr;
  logic [SB-1:0] stage_sel;
  tex_dcrs_t     act [NSLOT];
  tex_dcrs_t     rsp_q;
  logic          fire;

  assign off    = dcr_wr_addr - DCR_BASE;
  assign legal  = (dcr_wr_addr >= DCR_BASE) && (off <= 12'(6 + LOD_MAX));
  assign fld_wr = dcr_wr_valid && legal && (off != 12'd0);

  // Stage select; out-of-range stage numbers are dropped rather than wrapped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stage_sel <= '0;
    else if (dcr_wr_valid && legal && (off == 12'd0) && (dcr_wr_data < 32'(NUM_STAGES)))
      stage_sel <= dcr_wr_data[SB-1:0];
  end

  // Real banks for implemented stages; padding slots read as zero state.
  for (genvar s = 0; s < NSLOT; s++) begin : g_bank
    if (s < NUM_STAGES) begin : g_real
      tex_dcr_bank u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fld_wr && (stage_sel == SB'(s))),
        .wr_off  (off),
        .wr_data (dcr_wr_data),
        .commit  (commit),
        .active  (act[s])
      );
    end else begin : g_pad
      assign act[s] = '0;
    end
  end

  assign req_ready = !rsp_valid || rsp_ready;
  assign fire      = req_valid && req_ready;
  assign rsp_dcrs  = rsp_q;

  // Response register: load on fire, hold under backpressure, drain when consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_q     <= act[req_stage];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule
